// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared state codes, FSM states and defaults for the lift controller
package lift_pkg;

  localparam int DEFAULT_N_FLOORS = 4;

  localparam logic [1:0] ST_PARADO   = 2'd0;
  localparam logic [1:0] ST_SUBINDO  = 2'd1;
  localparam logic [1:0] ST_DESCENDO = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR      = 2'd3
  } state_e;

endpackage

// File: rtl/lift_timer.sv
// rtl/lift_timer.sv - loadable down-counter shared by the travel and door phases
module lift_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A load of N makes done true on the N-th edge after the load edge.
  assign done = (count_q == W'(1));

endmodule

// File: rtl/lift_motion_ctrl.sv
// rtl/lift_motion_ctrl.sv - elevator motion FSM with request latch and LCD refresh strobe
module lift_motion_ctrl
  import lift_pkg::*;
#(
  parameter int N_FLOORS      = DEFAULT_N_FLOORS,
  parameter int TRAVEL_CYCLES = 100_000_000,
  parameter int DOOR_CYCLES   = 150_000_000
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  input  logic [N_FLOORS-1:0]         req_i,
  output logic [1:0]                  estado_atual,
  output logic [$clog2(N_FLOORS)-1:0] floor_o,
  output logic                        door_open,
  output logic [N_FLOORS-1:0]         pending_o,
  output logic                        lcd_refresh
);

  localparam int FW   = $clog2(N_FLOORS);
  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES);
  localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES);

  state_e              state_q, state_d;
  logic                dir_up_q, dir_up_d;
  logic [FW-1:0]       floor_q, floor_d, eval_floor;
  logic [1:0]          estado_q, estado_d;
  logic                door_q, door_d;
  logic                lcd_q;
  logic [N_FLOORS-1:0] pending_q, clr;
  logic                moving, eval, above, below, go_up, go_dn;
  logic                tmr_load, tmr_done;
  logic [TW-1:0]       tmr_val;

  lift_timer #(.W(TW)) u_timer (
    .clk_i    (iCLK),
    .rst_ni   (iRST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign moving     = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
  assign eval_floor = (state_q == S_MOVE_UP)   ? floor_q + 1'b1 :
                      (state_q == S_MOVE_DOWN) ? floor_q - 1'b1 : floor_q;
  // A door re-request on the current floor restarts the timer instead of closing.
  assign eval = (state_q == S_IDLE) || (moving && tmr_done) ||
                ((state_q == S_DOOR) && tmr_done && !req_i[floor_q]);

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i] && (i > int'(eval_floor))) above = 1'b1;
      if (pending_q[i] && (i < int'(eval_floor))) below = 1'b1;
    end
  end

  assign go_up = above && (dir_up_q || !below);
  assign go_dn = below && (!dir_up_q || !above);

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    floor_d  = (moving && tmr_done) ? eval_floor : floor_q;
    estado_d = estado_q;
    door_d   = door_q;
    tmr_load = 1'b0;
    tmr_val  = TRAVEL_LD;
    clr      = '0;
    if (state_q == S_DOOR) begin
      clr[floor_q] = 1'b1;
      if (req_i[floor_q]) begin
        tmr_load = 1'b1;
        tmr_val  = DOOR_LD;
      end
    end
    if (eval) begin
      if (pending_q[eval_floor]) begin
        state_d          = S_DOOR;
        clr[eval_floor]  = 1'b1;
        tmr_load         = 1'b1;
        tmr_val          = DOOR_LD;
        estado_d         = ST_PARADO;
        door_d           = 1'b1;
      end else if (go_up) begin
        state_d  = S_MOVE_UP;
        dir_up_d = 1'b1;
        tmr_load = 1'b1;
        estado_d = ST_SUBINDO;
        door_d   = 1'b0;
      end else if (go_dn) begin
        state_d  = S_MOVE_DOWN;
        dir_up_d = 1'b0;
        tmr_load = 1'b1;
        estado_d = ST_DESCENDO;
        door_d   = 1'b0;
      end else begin
        state_d  = S_IDLE;
        estado_d = ST_PARADO;
        door_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      dir_up_q  <= 1'b1;
      floor_q   <= '0;
      estado_q  <= ST_PARADO;
      door_q    <= 1'b0;
      pending_q <= '0;
      lcd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_up_q  <= dir_up_d;
      floor_q   <= floor_d;
      estado_q  <= estado_d;
      door_q    <= door_d;
      pending_q <= (pending_q | req_i) & ~clr;
      lcd_q     <= (estado_d != estado_q);
    end
  end

  assign estado_atual = estado_q;
  assign floor_o      = floor_q;
  assign door_open    = door_q;
  assign pending_o    = pending_q;
  assign lcd_refresh  = lcd_q;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// tb/tb_lift_motion_ctrl.sv - table-driven self-checking bench for lift_motion_ctrl
module tb_lift_motion_ctrl;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [3:0] req_i;
  logic [1:0] estado_atual;
  logic [1:0] floor_o;
  logic       door_open;
  logic [3:0] pending_o;
  logic       lcd_refresh;

  int errors = 0;
  int checks = 0;

  lift_motion_ctrl #(
    .N_FLOORS      (4),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .req_i        (req_i),
    .estado_atual (estado_atual),
    .floor_o      (floor_o),
    .door_open    (door_open),
    .pending_o    (pending_o),
    .lcd_refresh  (lcd_refresh)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [3:0] req;
    int         n;
    logic [1:0] est;
    logic [1:0] fl;
    logic       door;
    logic [3:0] pend;
    logic       lcd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] req, input int n, input logic [1:0] est,
                              input logic [1:0] fl, input logic door, input logic [3:0] pend,
                              input logic lcd);
    vec_t v;
    v.req = req; v.n = n; v.est = est; v.fl = fl; v.door = door; v.pend = pend; v.lcd = lcd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input vec_t e);
    checks++;
    if (estado_atual !== e.est || floor_o !== e.fl || door_open !== e.door ||
        pending_o !== e.pend || lcd_refresh !== e.lcd) begin
      errors++;
      $display("FAIL %s t=%0t got est=%0d fl=%0d door=%0b pend=%b lcd=%0b exp est=%0d fl=%0d door=%0b pend=%b lcd=%0b",
               name, $time, estado_atual, floor_o, door_open, pending_o, lcd_refresh,
               e.est, e.fl, e.door, e.pend, e.lcd);
    end
  endtask

  vec_t zero;

  initial begin
    zero.req = '0; zero.n = 1; zero.est = 2'd0; zero.fl = 2'd0;
    zero.door = 1'b0; zero.pend = 4'b0; zero.lcd = 1'b0;

    // reset then idle
    add(4'b0000, 20, 0, 0, 0, 4'b0000, 0);
    // single request for floor 2 from floor 0
    add(4'b0100, 1, 0, 0, 0, 4'b0100, 0);
    add(4'b0000, 1, 1, 0, 0, 4'b0100, 1);
    add(4'b0000, 3, 1, 0, 0, 4'b0100, 0);
    add(4'b0000, 4, 1, 1, 0, 4'b0100, 0);
    add(4'b0000, 1, 0, 2, 1, 4'b0000, 1);
    add(4'b0000, 2, 0, 2, 1, 4'b0000, 0);
    add(4'b0000, 2, 0, 2, 0, 4'b0000, 0);
    // door open at 2, requests 3 and 0: up first, then reverse
    add(4'b0100, 1, 0, 2, 0, 4'b0100, 0);
    add(4'b0000, 1, 0, 2, 1, 4'b0000, 0);
    add(4'b1001, 1, 0, 2, 1, 4'b1001, 0);
    add(4'b0000, 1, 0, 2, 1, 4'b1001, 0);
    add(4'b0000, 1, 1, 2, 0, 4'b1001, 1);
    add(4'b0000, 3, 1, 2, 0, 4'b1001, 0);
    add(4'b0000, 1, 0, 3, 1, 4'b0001, 1);
    add(4'b0000, 2, 0, 3, 1, 4'b0001, 0);
    add(4'b0000, 1, 2, 3, 0, 4'b0001, 1);
    add(4'b0000, 3, 2, 3, 0, 4'b0001, 0);
    add(4'b0000, 4, 2, 2, 0, 4'b0001, 0);
    add(4'b0000, 4, 2, 1, 0, 4'b0001, 0);
    add(4'b0000, 1, 0, 0, 1, 4'b0000, 1);
    add(4'b0000, 2, 0, 0, 1, 4'b0000, 0);
    add(4'b0000, 2, 0, 0, 0, 4'b0000, 0);
    // going 0 -> 3, floor 1 requested mid-travel
    add(4'b1000, 1, 0, 0, 0, 4'b1000, 0);
    add(4'b0000, 1, 1, 0, 0, 4'b1000, 1);
    add(4'b0010, 1, 1, 0, 0, 4'b1010, 0);
    add(4'b0000, 2, 1, 0, 0, 4'b1010, 0);
    add(4'b0000, 1, 0, 1, 1, 4'b1000, 1);
    add(4'b0000, 2, 0, 1, 1, 4'b1000, 0);
    add(4'b0000, 1, 1, 1, 0, 4'b1000, 1);
    add(4'b0000, 3, 1, 1, 0, 4'b1000, 0);
    add(4'b0000, 4, 1, 2, 0, 4'b1000, 0);
    add(4'b0000, 1, 0, 3, 1, 4'b0000, 1);
    add(4'b0000, 2, 0, 3, 1, 4'b0000, 0);
    add(4'b0000, 2, 0, 3, 0, 4'b0000, 0);
    // current-floor request during DOOR restarts the door timer
    add(4'b1000, 1, 0, 3, 0, 4'b1000, 0);
    add(4'b0000, 1, 0, 3, 1, 4'b0000, 0);
    add(4'b1000, 1, 0, 3, 1, 4'b0000, 0);
    add(4'b0000, 2, 0, 3, 1, 4'b0000, 0);
    add(4'b1000, 1, 0, 3, 1, 4'b0000, 0);
    add(4'b0000, 2, 0, 3, 1, 4'b0000, 0);
    add(4'b0000, 2, 0, 3, 0, 4'b0000, 0);
    // descend toward 0, stopping mid-travel at floor 2 for the reset test
    add(4'b0001, 1, 0, 3, 0, 4'b0001, 0);
    add(4'b0000, 1, 2, 3, 0, 4'b0001, 1);
    add(4'b0000, 3, 2, 3, 0, 4'b0001, 0);
    add(4'b0000, 2, 2, 2, 0, 4'b0001, 0);

    iRST_N = 1'b0;
    req_i  = '0;
    #1;
    check("reset_async", zero);
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        req_i = (k == 0) ? vecs[v].req : 4'b0000;
        @(posedge iCLK);
        #1;
        check($sformatf("vec%0d.%0d", v, k), vecs[v]);
      end
    end

    // asynchronous reset mid-travel: outputs clear before the next edge
    #2;
    iRST_N = 1'b0;
    #1;
    check("reset_mid_travel", zero);
    @(posedge iCLK);
    #1;
    check("reset_held", zero);
    @(negedge iCLK);
    iRST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge iCLK);
      #1;
      check($sformatf("post_reset_idle%0d", k), zero);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
